// File: rtl/phase_gate_sequencer.sv
// Controlled-phase gate sequencer: scans a 2^N state vector in RAM and multiplies selected amplitudes by a phase.
// Latency: 1 cycle per skipped index, 5 cycles + multiplier wait per selected index, plus 1 FINISH cycle.
// Backpressure: stalls in WAIT until mul_done; cmd_start is only sampled while idle, never queued.
module phase_gate_sequencer #(
  parameter int INT_WIDTH  = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int N_QUBITS   = 3,
  parameter int QIDX_W     = 3,
  localparam int W = INT_WIDTH + FRAC_WIDTH,
  localparam int A = N_QUBITS
) (
  input  logic                clk,
  input  logic                rst,
  // command side (QFT controller)
  input  logic                cmd_start,
  input  logic [QIDX_W-1:0]   cmd_ctrl,
  input  logic [QIDX_W-1:0]   cmd_tgt,
  input  logic signed [W-1:0] cmd_phase_real,
  input  logic signed [W-1:0] cmd_phase_imag,
  output logic                busy,
  output logic                cmd_done,
  output logic                cmd_err,
  // amplitude RAM
  output logic [A-1:0]        mem_addr,
  output logic                mem_rd_en,
  input  logic signed [W-1:0] mem_rd_real,
  input  logic signed [W-1:0] mem_rd_imag,
  output logic                mem_wr_en,
  output logic signed [W-1:0] mem_wr_real,
  output logic signed [W-1:0] mem_wr_imag,
  // complex multiplier (this block is the master)
  output logic                mul_start,
  output logic signed [W-1:0] mul_a_real,
  output logic signed [W-1:0] mul_a_imag,
  output logic signed [W-1:0] mul_b_real,
  output logic signed [W-1:0] mul_b_imag,
  input  logic signed [W-1:0] mul_out_real,
  input  logic signed [W-1:0] mul_out_imag,
  input  logic                mul_done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_READ   = 3'd2,
    S_LATCH  = 3'd3,
    S_ISSUE  = 3'd4,
    S_WAIT   = 3'd5,
    S_WRITE  = 3'd6,
    S_FINISH = 3'd7
  } state_t;

  // Qubit count widened by one bit so an out-of-range index can be compared without overflow.
  localparam logic [QIDX_W:0] NQ       = (QIDX_W+1)'(N_QUBITS);
  localparam logic [A-1:0]    LAST_IDX = {A{1'b1}};

  state_t                state_q, state_d;
  logic [A-1:0]          idx_q, idx_d;
  logic [QIDX_W-1:0]     ctrl_q, ctrl_d;
  logic [QIDX_W-1:0]     tgt_q, tgt_d;
  logic                  err_q, err_d;
  logic signed [W-1:0]   ph_re_q, ph_re_d;
  logic signed [W-1:0]   ph_im_q, ph_im_d;
  logic signed [W-1:0]   a_re_q, a_re_d;
  logic signed [W-1:0]   a_im_q, a_im_d;
  logic signed [W-1:0]   p_re_q, p_re_d;
  logic signed [W-1:0]   p_im_q, p_im_d;

  logic [A-1:0]          ctrl_mask;
  logic [A-1:0]          tgt_mask;
  logic                  idx_sel;
  logic                  idx_last;
  logic                  cmd_bad;

  // Selection decode: index is selected when both its control and target bits are set.
  always_comb begin
    ctrl_mask = A'(1) << ctrl_q;
    tgt_mask  = A'(1) << tgt_q;
    idx_sel   = (|(idx_q & ctrl_mask)) && (|(idx_q & tgt_mask));
    idx_last  = (idx_q == LAST_IDX);
    cmd_bad   = ({1'b0, cmd_ctrl} >= NQ) || ({1'b0, cmd_tgt} >= NQ);
  end

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ctrl_q  <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
      ph_re_q <= '0;
      ph_im_q <= '0;
      a_re_q  <= '0;
      a_im_q  <= '0;
      p_re_q  <= '0;
      p_im_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ctrl_q  <= ctrl_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      ph_re_q <= ph_re_d;
      ph_im_q <= ph_im_d;
      a_re_q  <= a_re_d;
      a_im_q  <= a_im_d;
      p_re_q  <= p_re_d;
      p_im_q  <= p_im_d;
    end
  end

  // Next-state logic: walk the index space, detouring through read/multiply/write for selected entries.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ctrl_d  = ctrl_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    ph_re_d = ph_re_q;
    ph_im_d = ph_im_q;
    a_re_d  = a_re_q;
    a_im_d  = a_im_q;
    p_re_d  = p_re_q;
    p_im_d  = p_im_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          ctrl_d  = cmd_ctrl;
          tgt_d   = cmd_tgt;
          ph_re_d = cmd_phase_real;
          ph_im_d = cmd_phase_imag;
          idx_d   = '0;
          err_d   = cmd_bad;
          state_d = cmd_bad ? S_FINISH : S_SCAN;
        end
      end

      S_SCAN: begin
        if (idx_sel) begin
          state_d = S_READ;
        end else if (idx_last) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + A'(1);
        end
      end

      // Read data appears on the RAM port in the cycle after the strobe.
      S_READ: state_d = S_LATCH;

      S_LATCH: begin
        a_re_d  = mem_rd_real;
        a_im_d  = mem_rd_imag;
        state_d = S_ISSUE;
      end

      S_ISSUE: state_d = S_WAIT;

      // Operands are held in registers untouched here, so they stay stable until mul_done.
      S_WAIT: begin
        if (mul_done) begin
          p_re_d  = mul_out_real;
          p_im_d  = mul_out_imag;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (idx_last) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + A'(1);
          state_d = S_SCAN;
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Strobe and status decode straight from the state register, so reset clears them asynchronously.
  always_comb begin
    busy      = 1'b0;
    cmd_done  = 1'b0;
    cmd_err   = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE:   busy = 1'b0;
      S_READ:   begin busy = 1'b1; mem_rd_en = 1'b1; end
      S_ISSUE:  begin busy = 1'b1; mul_start = 1'b1; end
      S_WRITE:  begin busy = 1'b1; mem_wr_en = 1'b1; end
      S_FINISH: begin busy = 1'b1; cmd_done = 1'b1; cmd_err = err_q; end
      default:  busy = 1'b1;
    endcase
  end

  // Address, write data and multiplier operands come directly from registers.
  assign mem_addr    = idx_q;
  assign mem_wr_real = p_re_q;
  assign mem_wr_imag = p_im_q;
  assign mul_a_real  = a_re_q;
  assign mul_a_imag  = a_im_q;
  assign mul_b_real  = ph_re_q;
  assign mul_b_imag  = ph_im_q;

endmodule

// File: tb/tb_phase_gate_sequencer.sv
`timescale 1ns/1ps
module tb_phase_gate_sequencer;
  localparam int N     = 3;
  localparam int DEPTH = 8;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] re;
    logic [15:0] im;
  } wr_t;

  typedef struct {
    logic err;
    int   cycles;
    int   starts;
    int   reads;
  } done_t;

  logic clk = 1'b0;
  logic rst;
  logic cmd_start;
  logic [2:0] cmd_ctrl, cmd_tgt;
  logic signed [15:0] cmd_phase_real, cmd_phase_imag;
  logic busy, cmd_done, cmd_err;
  logic [2:0] mem_addr;
  logic mem_rd_en, mem_wr_en;
  logic signed [15:0] mem_rd_real, mem_rd_imag, mem_wr_real, mem_wr_imag;
  logic mul_start, mul_done;
  logic signed [15:0] mul_a_real, mul_a_imag, mul_b_real, mul_b_imag;
  logic signed [15:0] mul_out_real, mul_out_imag;

  int checks = 0;
  int errors = 0;

  wr_t   wq[$];
  done_t dq[$];

  logic signed [15:0] ram_re[DEPTH], ram_im[DEPTH];
  logic signed [15:0] ld_re[DEPTH], ld_im[DEPTH];
  logic signed [15:0] ref_re[DEPTH], ref_im[DEPTH];
  int ld_seq = 0;
  int ld_ack = 0;
  int mul_lat = 3;
  int glitch_req = 0;
  int glitch_ack = 0;
  bit mul_pend = 1'b0;

  phase_gate_sequencer #(.INT_WIDTH(8), .FRAC_WIDTH(8), .N_QUBITS(N), .QIDX_W(3)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_ctrl(cmd_ctrl), .cmd_tgt(cmd_tgt),
    .cmd_phase_real(cmd_phase_real), .cmd_phase_imag(cmd_phase_imag),
    .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_real(mem_rd_real), .mem_rd_imag(mem_rd_imag),
    .mem_wr_en(mem_wr_en), .mem_wr_real(mem_wr_real), .mem_wr_imag(mem_wr_imag),
    .mul_start(mul_start),
    .mul_a_real(mul_a_real), .mul_a_imag(mul_a_imag),
    .mul_b_real(mul_b_real), .mul_b_imag(mul_b_imag),
    .mul_out_real(mul_out_real), .mul_out_imag(mul_out_imag),
    .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Q8.8 complex product, truncated toward minus infinity: the multiplier's definition.
  function automatic logic [31:0] cmul(input logic signed [15:0] ar, input logic signed [15:0] ai,
                                       input logic signed [15:0] br, input logic signed [15:0] bi);
    longint re, im;
    re = (longint'(ar) * longint'(br) - longint'(ai) * longint'(bi)) >>> 8;
    im = (longint'(ar) * longint'(bi) + longint'(ai) * longint'(br)) >>> 8;
    return {re[15:0], im[15:0]};
  endfunction

  // Synchronous RAM: read data one cycle after the strobe, noise otherwise.
  always @(posedge clk) begin
    if (ld_ack != ld_seq) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram_re[i] <= ld_re[i];
        ram_im[i] <= ld_im[i];
      end
      ld_ack <= ld_seq;
    end else if (mem_wr_en) begin
      ram_re[mem_addr] <= mem_wr_real;
      ram_im[mem_addr] <= mem_wr_imag;
    end
    if (mem_rd_en) begin
      mem_rd_real <= ram_re[mem_addr];
      mem_rd_imag <= ram_im[mem_addr];
    end else begin
      mem_rd_real <= 16'($urandom);
      mem_rd_imag <= 16'($urandom);
    end
  end

  // Multiplier model: result mul_lat cycles after the start cycle; also injects stray done pulses on request.
  initial begin
    logic signed [15:0] ca_re, ca_im, cb_re, cb_im;
    logic [31:0] prod;
    int lat;
    bit aborted;
    mul_done = 1'b0;
    mul_out_real = 16'($urandom);
    mul_out_imag = 16'($urandom);
    forever begin
      @(negedge clk);
      if (mul_start === 1'b1 && !rst) begin
        mul_pend = 1'b1;
        aborted = 1'b0;
        ca_re = mul_a_real; ca_im = mul_a_imag;
        cb_re = mul_b_real; cb_im = mul_b_imag;
        prod = cmul(ca_re, ca_im, cb_re, cb_im);
        lat = mul_lat;
        for (int k = 1; k <= lat; k++) begin
          @(posedge clk);
          #1;
          if (k == lat) begin
            mul_done = 1'b1;
            mul_out_real = prod[31:16];
            mul_out_imag = prod[15:0];
          end
          @(negedge clk);
          if (rst) aborted = 1'b1;
          if (!aborted)
            chk("mul_operand_stable", {mul_a_real, mul_a_imag, mul_b_real, mul_b_imag},
                {ca_re, ca_im, cb_re, cb_im});
        end
        @(posedge clk);
        #1;
        mul_done = 1'b0;
        mul_out_real = 16'($urandom);
        mul_out_imag = 16'($urandom);
        mul_pend = 1'b0;
      end else if (glitch_req != glitch_ack) begin
        @(posedge clk);
        #1;
        mul_done = 1'b1;
        mul_out_real = 16'($urandom);
        mul_out_imag = 16'($urandom);
        @(posedge clk);
        #1;
        mul_done = 1'b0;
        glitch_ack = glitch_ack + 1;
      end
    end
  end

  // Monitor: pops expected writes and completions as the DUT presents them.
  initial begin
    int cyc, ns, nr;
    logic busy_prev;
    logic expect_idle;
    wr_t e;
    done_t d;
    cyc = 0; ns = 0; nr = 0;
    busy_prev = 1'b0;
    expect_idle = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_prev = 1'b0;
        expect_idle = 1'b0;
      end else begin
        if (expect_idle) begin
          chk("busy_low_after_done", busy, 0);
          expect_idle = 1'b0;
        end
        if (busy && !busy_prev) begin
          cyc = 0; ns = 0; nr = 0;
        end
        if (busy) cyc++;
        if (mul_start) ns++;
        if (mem_rd_en) nr++;
        if (mem_rd_en || mem_wr_en)
          chk("rd_wr_exclusive", {mem_rd_en, mem_wr_en}, {mem_rd_en, 1'b0} | {1'b0, ~mem_rd_en});
        if (mem_wr_en) begin
          checks++;
          if (wq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: addr=%0d data=(%0h,%0h), required no write",
                     mem_addr, mem_wr_real, mem_wr_imag);
          end else begin
            checks--;
            e = wq.pop_front();
            chk("write_addr_data", {mem_addr, mem_wr_real, mem_wr_imag}, {e.addr, e.re, e.im});
          end
        end
        if (cmd_done) begin
          checks++;
          if (dq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: cmd_done with no command outstanding, required none");
          end else begin
            checks--;
            d = dq.pop_front();
            chk("done_err", cmd_err, d.err);
            chk("done_cycle", cyc, d.cycles);
            chk("done_mul_starts", ns, d.starts);
            chk("done_reads", nr, d.reads);
            chk("done_busy", busy, 1);
          end
          expect_idle = 1'b1;
        end
        busy_prev = busy;
      end
    end
  end

  task automatic load(input logic [31:0] img[DEPTH]);
    int k;
    for (int i = 0; i < DEPTH; i++) begin
      ld_re[i] = img[i][31:16]; ld_im[i] = img[i][15:0];
      ref_re[i] = img[i][31:16]; ref_im[i] = img[i][15:0];
    end
    ld_seq = ld_seq + 1;
    k = 0;
    while (ld_ack != ld_seq && k < 20) begin @(negedge clk); k++; end
  endtask

  // Reference model: which indices change, in what order, and how long the command takes.
  task automatic issue(input int c, input int t, input logic [15:0] pr, input logic [15:0] pi);
    done_t d;
    int cyc, ns;
    logic [31:0] p;
    cyc = 1; ns = 0;
    if (c >= N || t >= N) begin
      d.err = 1'b1; d.cycles = 1; d.starts = 0; d.reads = 0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (((i >> c) & 1) == 1 && ((i >> t) & 1) == 1) begin
          p = cmul(ref_re[i], ref_im[i], pr, pi);
          wq.push_back('{addr: 3'(i), re: p[31:16], im: p[15:0]});
          ref_re[i] = p[31:16];
          ref_im[i] = p[15:0];
          cyc += 5 + mul_lat;
          ns++;
        end else begin
          cyc += 1;
        end
      end
      d.err = 1'b0; d.cycles = cyc; d.starts = ns; d.reads = ns;
    end
    dq.push_back(d);
    @(negedge clk);
    cmd_start = 1'b1;
    cmd_ctrl = 3'(c); cmd_tgt = 3'(t);
    cmd_phase_real = pr; cmd_phase_imag = pi;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
    cmd_ctrl = 3'($urandom); cmd_tgt = 3'($urandom);
    cmd_phase_real = 16'($urandom); cmd_phase_imag = 16'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (dq.size() != 0 && k < 3000) begin @(negedge clk); k++; end
    if (dq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d completions outstanding, required 0", tag, dq.size());
      dq.delete();
      wq.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_ram(input string tag);
    for (int i = 0; i < DEPTH; i++)
      chk($sformatf("%s_ram%0d", tag, i), {ram_re[i], ram_im[i]}, {ref_re[i], ref_im[i]});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cmd_done"}, cmd_done, 0);
    chk({tag, "_cmd_err"}, cmd_err, 0);
    chk({tag, "_strobes"}, {mem_rd_en, mem_wr_en, mul_start}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_wr_data"}, {mem_wr_real, mem_wr_imag}, 0);
    chk({tag, "_mul_a"}, {mul_a_real, mul_a_imag}, 0);
    chk({tag, "_mul_b"}, {mul_b_real, mul_b_imag}, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] img1[DEPTH];
    logic [31:0] img2[DEPTH];
    logic [31:0] rimg[DEPTH];
    int seen, k, c, t;

    for (int i = 0; i < DEPTH; i++) begin
      img1[i] = 32'h0040_0000;
      img2[i] = 32'h0100_0080;
    end
    img1[3] = 32'h0080_0000;
    img1[7] = 32'h0100_0100;

    rst = 1'b0;
    cmd_start = 1'b0; cmd_ctrl = '0; cmd_tgt = '0;
    cmd_phase_real = '0; cmd_phase_imag = '0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Test 1: ctrl=0, tgt=1, phase i.
    mul_lat = 3;
    load(img1);
    issue(0, 1, 16'h0000, 16'h0100);
    wait_done("t1");
    check_ram("t1");
    chk("t1_ram3_const", {ram_re[3], ram_im[3]}, 32'h0000_0080);
    chk("t1_ram7_const", {ram_re[7], ram_im[7]}, 32'hFF00_0100);
    chk("t1_ram0_const", {ram_re[0], ram_im[0]}, 32'h0040_0000);

    // Test 2: ctrl == tgt == 2, phase -1.
    load(img2);
    issue(2, 2, 16'hFF00, 16'h0000);
    wait_done("t2");
    check_ram("t2");
    chk("t2_ram4_const", {ram_re[4], ram_im[4]}, 32'hFF00_FF80);
    chk("t2_ram7_const", {ram_re[7], ram_im[7]}, 32'hFF00_FF80);
    chk("t2_ram2_const", {ram_re[2], ram_im[2]}, 32'h0100_0080);

    // Test 3: out-of-range control qubit is rejected.
    issue(5, 1, 16'h0100, 16'h0000);
    wait_done("t3");
    check_ram("t3");

    // Test 4: stray mul_done in SCAN and a second cmd_start while busy.
    load(img1);
    issue(0, 1, 16'h0000, 16'h0100);
    glitch_req = glitch_req + 1;
    repeat (4) @(negedge clk);
    cmd_start = 1'b1; cmd_ctrl = 3'd2; cmd_tgt = 3'd2;
    @(posedge clk);
    #1 cmd_start = 1'b0;
    wait_done("t4");
    check_ram("t4");

    // Test 5: multiplier ten cycles slower.
    mul_lat = 13;
    load(img1);
    issue(0, 1, 16'h0000, 16'h0100);
    wait_done("t5");
    check_ram("t5");
    chk("t5_ram7_const", {ram_re[7], ram_im[7]}, 32'hFF00_0100);

    // Test 6: reset during WAIT of index 7, then reissue.
    mul_lat = 3;
    load(img1);
    issue(0, 1, 16'h0000, 16'h0100);
    seen = 0;
    k = 0;
    while (seen < 2 && k < 200) begin
      @(negedge clk);
      if (mul_start) seen++;
      k++;
    end
    chk("t6_second_issue_seen", seen, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("t6_abort");
    chk("t6_writes_left", wq.size(), 1);
    chk("t6_done_left", dq.size(), 1);
    wq.delete();
    dq.delete();
    ref_re[7] = 16'h0100;
    ref_im[7] = 16'h0100;
    @(negedge clk);
    #1 rst = 1'b0;
    k = 0;
    while (mul_pend && k < 50) begin @(negedge clk); k++; end
    repeat (3) @(negedge clk);
    chk("t6_ram7_kept", {ram_re[7], ram_im[7]}, 32'h0100_0100);
    check_ram("t6_abort");
    issue(0, 1, 16'h0000, 16'h0100);
    wait_done("t6_reissue");
    check_ram("t6_reissue");

    // Randomized commands.
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < DEPTH; i++) rimg[i] = $urandom;
      load(rimg);
      mul_lat = $urandom_range(1, 6);
      c = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 2) : $urandom_range(3, 7);
      t = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 2) : $urandom_range(3, 7);
      issue(c, t, 16'($urandom), 16'($urandom));
      wait_done("rand");
      check_ram("rand");
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
